// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller: ALU operation codes,
// R-type funct and I-type opcode values, and the issue FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_NOTA  = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0110;
  localparam logic [3:0] OP_ADDPP = 4'b1000;
  localparam logic [3:0] OP_ADDPN = 4'b1001;
  localparam logic [3:0] OP_ADDNP = 4'b1010;
  localparam logic [3:0] OP_ADDNN = 4'b1011;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_t;
  typedef enum logic {DEST_RD, DEST_RT} dest_t;

  // Sign-magnitude add variants encode the operand sign pair in the low two bits.
  function automatic logic [3:0] add_op(input logic sa, input logic sb);
    return {2'b10, sa, sb};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct and operand signs into the ALU operation,
// destination field select and a legality flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       imm15,
  input  logic       sign_a,
  input  logic       sign_b,
  output logic [3:0] operation,
  output dest_t      dest_sel,
  output logic       legal
);

  always_comb begin
    operation = OP_NOTA;
    dest_sel  = DEST_RD;
    legal     = 1'b1;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FN_ADD:  operation = add_op(sign_a, sign_b);
        // Subtraction is an add with the sign of B flipped.
        FN_SUB:  operation = add_op(sign_a, ~sign_b);
        FN_ADDU: operation = OP_ADDPP;
        FN_SUBU: operation = OP_ADDPN;
        FN_AND:  operation = OP_AND;
        FN_OR:   operation = OP_OR;
        FN_XOR:  operation = OP_XOR;
        FN_NOR:  operation = OP_NOR;
        default: legal = 1'b0;
      endcase
    end else begin
      dest_sel = DEST_RT;
      case (opcode)
        OPC_ADDI:  operation = add_op(sign_a, imm15);
        OPC_ADDIU: operation = OP_ADDPP;
        OPC_ANDI:  operation = OP_AND;
        OPC_ORI:   operation = OP_OR;
        OPC_XORI:  operation = OP_XOR;
        default:   legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, runs DECODE/EXEC/WB, hands the
// destination register to writeback and keeps saturating debug counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic             alu_en,
  output logic [3:0]       Operation,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_reg,
  output logic             wb_we,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state_reg;
  logic [31:0] instr_reg;
  logic [3:0]  dec_op;
  dest_t       dec_dest;
  logic        dec_legal;
  logic [4:0]  dec_reg;
  logic        unused_bits;

  alu_op_decode u_decode (
    .opcode   (instr_reg[31:26]),
    .funct    (instr_reg[5:0]),
    .imm15    (instr_reg[15]),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .operation(dec_op),
    .dest_sel (dec_dest),
    .legal    (dec_legal)
  );

  // rs and shamt fields play no part in issue control.
  assign unused_bits = ^{instr_reg[25:21], instr_reg[10:6]};

  assign dec_reg     = (dec_dest == DEST_RD) ? instr_reg[15:11] : instr_reg[20:16];
  assign instr_ready = (state_reg == ST_IDLE);
  assign illegal     = (state_reg == ST_DECODE) && !dec_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      instr_reg   <= '0;
      alu_en      <= 1'b0;
      Operation   <= OP_NOTA;
      wb_valid    <= 1'b0;
      wb_reg      <= '0;
      wb_we       <= 1'b0;
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_reg <= instr;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          Operation <= dec_op;
          wb_reg    <= dec_reg;
          wb_we     <= (dec_reg != 5'd0);
          if (dec_legal) begin
            alu_en    <= 1'b1;
            state_reg <= ST_EXEC;
          end else begin
            if (illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + CNT_W'(1);
            state_reg <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          alu_en    <= 1'b0;
          wb_valid  <= 1'b1;
          state_reg <= ST_WB;
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            if (retired_cnt != CNT_MAX) retired_cnt <= retired_cnt + CNT_W'(1);
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue controller sitting between instruction decode and the sign-magnitude ALU.
- Accepts one R-type or I-type arithmetic/logic instruction per handshake and decodes opcode/funct plus operand signs into the 4-bit ALU operation code.
- Sequences the ALU through a fixed DECODE/EXEC/WB schedule, then hands the destination register to writeback with a valid/ready handshake.
- Keeps retired and illegal instruction counters for debug.

Parameters:
CNT_W, 16, width of the retired and illegal counters (saturating)

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_valid  in  1  instruction word is present.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  32  instruction word: [31:26] opcode, [20:16] rt, [15:11] rd, [15:0] immediate, [5:0] funct.
- sign_a  in  1  sign bit of operand A (rs value), valid in DECODE.
- sign_b  in  1  sign bit of register operand B (rt value), valid in DECODE.
- alu_en  out  1  ALU result is to be captured this cycle.
- Operation  out  4  ALU operation code.
- wb_valid  out  1  result ready for writeback.
- wb_ready  in  1  writeback accepts.
- wb_reg  out  5  destination register number.
- wb_we  out  1  write enable; 0 when destination is register 0.
- illegal  out  1  one-cycle pulse for an unsupported instruction.
- retired_cnt  out  CNT_W  instructions completed through writeback.
- illegal_cnt  out  CNT_W  illegal instructions seen.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - instr_ready=1 (combinational: high only in IDLE).
  - alu_en=0, Operation=4'b0000, wb_valid=0, wb_reg=0, wb_we=0, illegal=0.
  - Both counters are 0.
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE: on instr_valid && instr_ready, latch instr and go to DECODE. Otherwise stay.
- DECODE:
  - Sample sign_a and sign_b.
  - Compute and register Operation, wb_reg and wb_we.
  - Legal instruction: go to EXEC.
  - Illegal instruction: pulse illegal for this cycle, increment illegal_cnt, return to IDLE. wb_valid is never raised.
- EXEC: alu_en=1 for exactly one cycle; Operation is held stable. Go to WB.
- WB:
  - wb_valid=1; wb_reg, wb_we and Operation are held.
  - Stay in WB until wb_ready.
  - On wb_ready, increment retired_cnt and go to IDLE.
  - wb_ready sampled outside WB is ignored.
- Latency: accept edge at cycle 0, DECODE at cycle 1, alu_en at cycle 2, wb_valid at cycle 3 at the earliest. Throughput is one instruction per 4 cycles when wb_ready is tied high.
- R-type decode (opcode 0x00), destination rd:
  - funct 0x20 add: sign pair (a,b) maps 00→ADDPP 1000, 01→ADDPN 1001, 10→ADDNP 1010, 11→ADDNN 1011.
  - funct 0x22 sub: same mapping with b inverted.
  - funct 0x21 addu → 1000.
  - funct 0x23 subu → 1001.
  - funct 0x24 and → 0010.
  - funct 0x25 or → 0011.
  - funct 0x26 xor → 0100.
  - funct 0x27 nor → 0110.
  - Any other funct is illegal.
- I-type decode, destination rt, b-sign = immediate[15] (sign_b ignored):
  - opcode 0x08 addi: add mapping.
  - opcode 0x09 addiu → 1000.
  - opcode 0x0C andi → 0010.
  - opcode 0x0D ori → 0011.
  - opcode 0x0E xori → 0100.
  - Any other opcode is illegal.
- wb_we = (wb_reg != 0). A write to register 0 still completes the handshake and still counts as retired.
- Counters saturate at all-ones; they never wrap.
- rst in any state: returns to IDLE next edge, applies all reset values, drops any in-flight instruction without counting it.
- instr_valid while not in IDLE: ignored, because instr_ready=0.

Decomposition:
- Package alu_pkg holds:
  - the ALU operation codes (NOTA..ADDNN);
  - the funct constants 0x20–0x27;
  - the I-type opcode constants;
  - the FSM state enum.
- One sub-module, alu_op_decode: purely combinational. Inputs are opcode, funct, imm15, sign_a and sign_b. Outputs are Operation, dest_sel (rd/rt) and legal.

Test Plan:
- add, sign_a=1, sign_b=0, rd=5, wb_ready=1 → Operation=1010, alu_en at cycle 2, wb_valid at cycle 3 with wb_reg=5, wb_we=1, retired_cnt=1.
- sub, sign_a=0, sign_b=1 → Operation=1000. Then subu with any signs → 1001.
- addi with immediate=0xFFF0, sign_a=0, rt=9 → Operation=1001, wb_reg=9. Then ori → 0011.
- R-type funct 0x00 → illegal pulse at cycle 1, no wb_valid, illegal_cnt=1, instr_ready=1 at cycle 2.
- and with rd=0, wb_ready held low 5 cycles → wb_valid stays high, Operation=0010 stable, wb_we=0. Raising wb_ready gives retired_cnt+1 and IDLE next cycle.
- rst asserted during EXEC → next cycle all outputs at reset values, counters 0. A fresh instruction is accepted immediately after rst drops.
